// File: rtl/mcp3002_emulator_pkg.sv
// Shared definitions for the MCP3002 SPI responder: FSM states, result width,
// bit-counter landmarks and the clamped differential subtract.
package mcp3002_defs;

   localparam int MCP3002_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_CMD,
      ST_DATA,
      ST_TAIL
   } state_e;

   // Counter holds the index of the bit just driven: null=0, B9=1 .. B0=10.
   localparam logic [4:0] CNT_NULL      = 5'd0;
   localparam logic [4:0] CNT_CMD_DONE  = 5'd3;
   localparam logic [4:0] CNT_B0        = 5'd10;
   localparam logic [4:0] CNT_TAIL_LAST = 5'd19;
   localparam logic [4:0] CNT_SAT       = 5'd20;

   function automatic logic [MCP3002_BITS-1:0] sub_clamp(
      input logic [MCP3002_BITS-1:0] a,
      input logic [MCP3002_BITS-1:0] b
   );
      logic signed [MCP3002_BITS:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      return diff[MCP3002_BITS] ? '0 : diff[MCP3002_BITS-1:0];
   endfunction

endpackage

// File: rtl/mcp3002_emulator_spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with optional
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_input_sync #(
   parameter int STAGES  = 2,
   parameter bit EDGES   = 1'b1,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign sync_o = sync_q[STAGES-1];
   assign rise_o = EDGES ? (sync_q[STAGES-1] & ~prev_q) : 1'b0;
   assign fall_o = EDGES ? (~sync_q[STAGES-1] & prev_q) : 1'b0;

endmodule

// File: rtl/mcp3002_emulator.sv
// SPI responder mimicking one MCP3002: decodes start/SGL/ODD/MSBF and returns a
// 10-bit result (channel inputs, clamped difference, or an internal ramp) on miso.
module mcp3002_emulator
   import mcp3002_defs::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int RAMP_MODE   = 0,
   parameter int RAMP_STEP   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    spi_clock,
   input  logic                    chip_select,
   input  logic                    mosi,
   input  logic [MCP3002_BITS-1:0] ch0_value,
   input  logic [MCP3002_BITS-1:0] ch1_value,
   output logic                    miso,
   output logic                    miso_oe,
   output logic                    sample_strobe,
   output logic [1:0]              sample_channel,
   output logic [MCP3002_BITS-1:0] sample_data,
   output logic                    frame_error
);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
   logic sclk_level_unused, cs_level_unused, mosi_rise_unused, mosi_fall_unused;

   spi_input_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din_i(spi_clock),
      .sync_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   // CS resets high so a deasserted pin never looks like a frame start.
   spi_input_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .din_i(chip_select),
      .sync_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_input_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din_i(mosi),
      .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
   );

   state_e                  state_q;
   logic [4:0]              cnt_q;
   logic [4:0]              cnt_inc;
   logic                    sgl_q, odd_q, msbf_q;
   logic [MCP3002_BITS-1:0] hold_q, ramp_q, result_d;
   logic                    miso_q, miso_oe_q, strobe_q, frame_error_q;
   logic [1:0]              channel_q;
   logic [MCP3002_BITS-1:0] data_q;

   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;

   always_comb begin
      result_d = '0;
      if (RAMP_MODE != 0)
         result_d = ramp_q;
      else if (sgl_q)
         result_d = odd_q ? ch1_value : ch0_value;
      else if (odd_q)
         result_d = sub_clamp(ch1_value, ch0_value);
      else
         result_d = sub_clamp(ch0_value, ch1_value);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= CNT_NULL;
         sgl_q         <= 1'b0;
         odd_q         <= 1'b0;
         msbf_q        <= 1'b0;
         hold_q        <= '0;
         ramp_q        <= '0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         strobe_q      <= 1'b0;
         frame_error_q <= 1'b0;
         channel_q     <= '0;
         data_q        <= '0;
      end else begin
         strobe_q      <= 1'b0;
         frame_error_q <= 1'b0;
         // Deselect beats any sclk edge seen in the same cycle.
         if (state_q != ST_IDLE && cs_rise) begin
            state_q       <= ST_IDLE;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            frame_error_q <= (state_q == ST_CMD) || (state_q == ST_DATA);
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (cs_fall) state_q <= ST_WAIT_START;
               end
               ST_WAIT_START: begin
                  if (sclk_rise && mosi_s) begin
                     state_q <= ST_CMD;
                     cnt_q   <= CNT_NULL;
                  end
               end
               ST_CMD: begin
                  if (sclk_rise && cnt_q != CNT_CMD_DONE) begin
                     cnt_q <= cnt_inc;
                     case (cnt_q)
                        5'd0:    sgl_q  <= mosi_s;
                        5'd1:    odd_q  <= mosi_s;
                        default: msbf_q <= mosi_s;
                     endcase
                  end else if (sclk_fall && cnt_q == CNT_CMD_DONE) begin
                     hold_q    <= result_d;
                     miso_q    <= 1'b0;
                     miso_oe_q <= 1'b1;
                     cnt_q     <= CNT_NULL;
                     state_q   <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (sclk_fall) begin
                     cnt_q  <= cnt_inc;
                     miso_q <= hold_q[4'(CNT_B0 - cnt_inc)];
                     if (cnt_inc == CNT_B0) begin
                        strobe_q  <= 1'b1;
                        channel_q <= {sgl_q, odd_q};
                        data_q    <= hold_q;
                        if (RAMP_MODE != 0) ramp_q <= ramp_q + 10'(RAMP_STEP);
                        state_q   <= ST_TAIL;
                     end
                  end
               end
               ST_TAIL: begin
                  if (sclk_fall) begin
                     cnt_q  <= cnt_inc;
                     miso_q <= (!msbf_q && cnt_inc <= CNT_TAIL_LAST) ?
                               hold_q[4'(cnt_inc - CNT_B0)] : 1'b0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign miso           = miso_q;
   assign miso_oe        = miso_oe_q;
   assign sample_strobe  = strobe_q;
   assign sample_channel = channel_q;
   assign sample_data    = data_q;
   assign frame_error    = frame_error_q;

endmodule

// File: tb/tb_mcp3002_emulator.sv
// Bench for mcp3002_emulator: a channel-value instance and a ramp instance share
// one SPI master; outputs are compared with a stream-level model of the ADC.
module tb_mcp3002_emulator;

   logic       clk = 1'b0;
   logic       rst, spi_clock, chip_select, mosi;
   logic [9:0] ch0, ch1;

   logic       miso0, oe0, stb0, ferr0;
   logic [1:0] chn0;
   logic [9:0] dat0;
   logic       misor, oer, stbr, ferrr;
   logic [1:0] chnr;
   logic [9:0] datr;

   mcp3002_emulator #(.SYNC_STAGES(2), .RAMP_MODE(0), .RAMP_STEP(1)) dut (
      .clk(clk), .rst(rst), .spi_clock(spi_clock), .chip_select(chip_select), .mosi(mosi),
      .ch0_value(ch0), .ch1_value(ch1), .miso(miso0), .miso_oe(oe0),
      .sample_strobe(stb0), .sample_channel(chn0), .sample_data(dat0), .frame_error(ferr0)
   );

   mcp3002_emulator #(.SYNC_STAGES(2), .RAMP_MODE(1), .RAMP_STEP(1)) dut_r (
      .clk(clk), .rst(rst), .spi_clock(spi_clock), .chip_select(chip_select), .mosi(mosi),
      .ch0_value(ch0), .ch1_value(ch1), .miso(misor), .miso_oe(oer),
      .sample_strobe(stbr), .sample_channel(chnr), .sample_data(datr), .frame_error(ferrr)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          err0 = 0;
   int          errr = 0;
   int          ramp_m = 0;
   logic [11:0] q0[$];
   logic [11:0] qr[$];

   always @(negedge clk) begin
      if (stb0) q0.push_back({chn0, dat0});
      if (stbr) qr.push_back({chnr, datr});
      if (ferr0) err0 = err0 + 1;
      if (ferrr) errr = errr + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic int model_value(input bit sgl, input bit odd, input int a, input int b);
      int d;
      if (sgl) return odd ? b : a;
      d = odd ? (b - a) : (a - b);
      return (d < 0) ? 0 : d;
   endfunction

   task automatic sbit(input bit b, input int half);
      mosi = b;
      wait_clk(half);
      spi_clock = 1'b1;
      wait_clk(half);
      spi_clock = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " miso"}, miso0, 0);
      check({tag, " miso_oe"}, oe0, 0);
      check({tag, " strobe"}, stb0, 0);
      check({tag, " ferr"}, ferr0, 0);
      check({tag, " chan"}, chn0, 0);
      check({tag, " data"}, dat0, 0);
      check({tag, " ramp data"}, datr, 0);
      check({tag, " ramp oe"}, oer, 0);
   endtask

   // abort_at < 0: run the frame out; otherwise stop after that many falls past the null bit.
   task automatic frame(input bit sgl, input bit odd, input bit msbf, input int lead,
                        input int half, input int abort_at, input bit do_rst,
                        input bit chk, input bit scramble);
      int   exp_v, nfalls, e0, er;
      bit   stream[$];
      bit   completed, exp_err;
      logic [11:0] item;
      exp_v = model_value(sgl, odd, int'(ch0), int'(ch1));
      stream.push_back(1'b0);
      for (int i = 9; i >= 0; i--) stream.push_back(exp_v[i]);
      if (!msbf) for (int i = 1; i <= 9; i++) stream.push_back(exp_v[i]);
      nfalls    = (abort_at >= 0) ? abort_at : (msbf ? 12 : 21);
      completed = (abort_at < 0) || (abort_at >= 10);
      exp_err   = (abort_at >= 0) && (abort_at < 10);
      e0 = err0;
      er = errr;
      q0.delete();
      qr.delete();

      chip_select = 1'b0;
      wait_clk(half);
      repeat (lead) sbit(1'b0, half);
      sbit(1'b1, half);
      sbit(sgl, half);
      sbit(odd, half);
      sbit(msbf, half);
      wait_clk(half);
      if (chk) begin
         check("null oe", oe0, 1);
         check("null bit", miso0, 0);
      end
      for (int k = 1; k <= nfalls; k++) begin
         spi_clock = 1'b1;
         wait_clk(half);
         spi_clock = 1'b0;
         if (scramble && k == 3) begin
            ch0 = 10'($urandom_range(0, 1023));
            ch1 = 10'($urandom_range(0, 1023));
         end
         wait_clk(half);
         if (chk) begin
            check($sformatf("miso fall %0d", k), miso0, (k < stream.size()) ? stream[k] : 1'b0);
            check($sformatf("oe fall %0d", k), oe0, 1);
         end
      end

      if (do_rst) begin
         rst = 1'b1;
         chip_select = 1'b1;
         mosi = 1'b0;
         wait_clk(1);
         check_reset_outputs("rst mid-data");
         wait_clk(3);
         rst = 1'b0;
         ramp_m = 0;
         wait_clk(2);
         return;
      end

      chip_select = 1'b1;
      wait_clk(5);
      check("deselect oe", oe0, 0);
      check("deselect miso", miso0, 0);
      check("ferr count", err0 - e0, exp_err);
      check("ramp ferr count", errr - er, exp_err);
      check("strobe count", q0.size(), completed);
      check("ramp strobe count", qr.size(), completed);
      if (completed && q0.size() > 0) begin
         item = q0.pop_front();
         check("sample_data", item[9:0], exp_v);
         check("sample_channel", item[11:10], {sgl, odd});
      end
      if (completed && qr.size() > 0) begin
         item = qr.pop_front();
         check("ramp data", item[9:0], ramp_m);
         check("ramp channel", item[11:10], {sgl, odd});
      end
      if (completed) ramp_m = (ramp_m + 1) % 1024;
   endtask

   task automatic early_abort(input int lead, input bit send_start, input int ncmd);
      int e0, er;
      e0 = err0;
      er = errr;
      q0.delete();
      qr.delete();
      chip_select = 1'b0;
      wait_clk(5);
      repeat (lead) sbit(1'b0, 5);
      if (send_start) begin
         sbit(1'b1, 5);
         for (int i = 0; i < ncmd; i++) sbit(1'($urandom_range(0, 1)), 5);
      end
      wait_clk(5);
      chip_select = 1'b1;
      wait_clk(6);
      check("early abort oe", oe0, 0);
      check("early abort ferr", err0 - e0, send_start);
      check("early abort ramp ferr", errr - er, send_start);
      check("early abort strobes", q0.size() + qr.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      spi_clock = 1'b0;
      chip_select = 1'b1;
      mosi = 1'b0;
      ch0 = '0;
      ch1 = '0;
      wait_clk(5);
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_clk(4);
      check_reset_outputs("idle after reset");

      ch0 = 10'h2A5;
      ch1 = 10'h0F0;
      frame(1'b1, 1'b0, 1'b1, 0, 5, -1, 1'b0, 1'b1, 1'b0);

      ch0 = 10'h011;
      ch1 = 10'h301;
      frame(1'b1, 1'b1, 1'b0, 0, 5, -1, 1'b0, 1'b1, 1'b0);

      ch0 = 10'd5;
      ch1 = 10'd9;
      frame(1'b0, 1'b0, 1'b1, 0, 5, -1, 1'b0, 1'b1, 1'b0);
      frame(1'b0, 1'b1, 1'b1, 0, 5, -1, 1'b0, 1'b1, 1'b0);

      ch0 = 10'h3FF;
      ch1 = 10'h000;
      frame(1'b0, 1'b0, 1'b0, 1, 5, -1, 1'b0, 1'b1, 1'b1);

      ch0 = 10'h155;
      ch1 = 10'h2AA;
      frame(1'b1, 1'b0, 1'b1, 0, 5, 4, 1'b0, 1'b1, 1'b0);
      frame(1'b1, 1'b1, 1'b1, 0, 5, -1, 1'b0, 1'b1, 1'b0);
      frame(1'b1, 1'b0, 1'b0, 0, 5, 12, 1'b0, 1'b1, 1'b0);

      early_abort(2, 1'b0, 0);
      early_abort(1, 1'b1, 1);
      early_abort(0, 1'b1, 2);

      ch0 = 10'h1C3;
      frame(1'b1, 1'b0, 1'b1, 3, 5, -1, 1'b0, 1'b1, 1'b0);

      frame(1'b1, 1'b0, 1'b1, 1, 5, 3, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 1030; i++) begin
         ch0 = 10'($urandom_range(0, 1023));
         ch1 = 10'($urandom_range(0, 1023));
         frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 0, 2, 10,
               1'b0, 1'b0, 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         ch0 = 10'($urandom_range(0, 1023));
         ch1 = 10'($urandom_range(0, 1023));
         frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 5, -1, 1'b0, 1'b1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
